// File: rtl/neotang_clk_pkg.sv
// Shared types and 27 MHz default timing for the clock/reset supervisor.
//   state_t : supervisor FSM states
//   DEF_*   : default cycle counts for a 27 MHz clkin
//   max3    : helper used to size the shared down-counter
package neotang_clk_pkg;

  typedef enum logic [2:0] {
    RSTPLL  = 3'd0,
    WAIT    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam int DEF_PLL_RST_CYCLES      = 27;     // 1 us
  localparam int DEF_LOCK_STABLE_CYCLES  = 2700;   // 100 us
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 27000;  // 1 ms
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_RST_STAGGER_CYCLES  = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop vector synchronizer, asynchronous reset to 0.
//   clk, rst : destination clock / async active-high reset
//   d        : asynchronous input vector
//   q        : synchronized output (2 cycles latency)
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL resets, waits for stable lock on every PLL,
// releases the per-domain resets in index order and re-sequences on lock loss.
// Runs on the board clock only.
//   clkin, rst        : reference clock, async active-high reset
//   pll_lock_in       : raw lock indicators (asynchronous)
//   clear_status      : clears lock_lost_sticky (a same-cycle set wins)
//   pll_rst           : per-PLL reset
//   domain_rst        : per-domain reset, bit i follows PLL i
//   all_locked, fault : high in RUN / FAULT
//   retry_count       : failed lock attempts since the last RUN
//   lock_lost_sticky  : PLLs that dropped lock during RELEASE/RUN
module pll_lock_supervisor
  import neotang_clk_pkg::*;
#(
  parameter int NUM_PLL             = 2,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int RST_STAGGER_CYCLES  = DEF_RST_STAGGER_CYCLES
) (
  input  logic                             clkin,
  input  logic                             rst,
  input  logic [NUM_PLL-1:0]               pll_lock_in,
  input  logic                             clear_status,
  output logic [NUM_PLL-1:0]               pll_rst,
  output logic [NUM_PLL-1:0]               domain_rst,
  output logic                             all_locked,
  output logic                             fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
  output logic [NUM_PLL-1:0]               lock_lost_sticky
);

  // Timeout exceeds the stable window, so the widest load also covers STABLE+1.
  localparam int CW = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, RST_STAGGER_CYCLES)) + 1;
  localparam int RW = $clog2(MAX_RETRIES+1);
  localparam int IW = $clog2(NUM_PLL+1);

  localparam logic [CW-1:0] P_LD    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] T_LD    = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] G_LD    = CW'(RST_STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] S_LD    = CW'(LOCK_STABLE_CYCLES - 1);
  // The first two samples in WAIT still reflect lock as seen while the PLL
  // was held in reset (synchronizer latency), so they are not credited.
  localparam logic [CW-1:0] S_ENTRY = CW'(LOCK_STABLE_CYCLES + 1);
  localparam logic [IW-1:0] N_IDX   = IW'(NUM_PLL);

  logic [NUM_PLL-1:0] lock_s;
  logic               all_s;

  sync_2ff #(.W(NUM_PLL)) u_sync (
    .clk (clkin),
    .rst (rst),
    .d   (pll_lock_in),
    .q   (lock_s)
  );

  assign all_s = &lock_s;

  state_t             state, state_d;
  logic [CW-1:0]      cnt, cnt_d, stab, stab_d;
  logic [IW-1:0]      idx, idx_d;      // number of domain resets released
  logic [RW-1:0]      retry_d;
  logic [NUM_PLL-1:0] lost_set;
  logic [NUM_PLL-1:0] pll_rst_d, dom_d, sticky_d;
  logic               all_locked_d, fault_d;

  // State register
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state <= RSTPLL;
      cnt   <= P_LD;
      stab  <= S_ENTRY;
      idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      stab  <= stab_d;
      idx   <= idx_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state;
    cnt_d    = cnt - 1'b1;
    stab_d   = stab;
    idx_d    = idx;
    retry_d  = retry_count;
    lost_set = '0;
    unique case (state)
      RSTPLL: begin
        if (cnt == '0) begin
          state_d = WAIT;
          cnt_d   = T_LD;
          stab_d  = S_ENTRY;
        end
      end
      WAIT: begin
        stab_d = all_s ? (stab - 1'b1) : S_LD;
        if (all_s && stab == '0) begin
          state_d = RELEASE;
          idx_d   = IW'(1);
          cnt_d   = (NUM_PLL == 1) ? '0 : G_LD;
        end else if (cnt == '0) begin
          retry_d = retry_count + 1'b1;
          cnt_d   = P_LD;
          state_d = (retry_d == RW'(MAX_RETRIES)) ? FAULT : RSTPLL;
        end
      end
      RELEASE: begin
        if (!all_s) begin
          lost_set = ~lock_s;
          state_d  = RSTPLL;
          idx_d    = '0;
          cnt_d    = P_LD;
        end else if (cnt == '0) begin
          if (idx == N_IDX) begin
            state_d = RUN;
          end else begin
            // After the last release, wait one cycle before RUN.
            idx_d = idx + 1'b1;
            cnt_d = (idx_d == N_IDX) ? '0 : G_LD;
          end
        end
      end
      RUN: begin
        if (!all_s) begin
          lost_set = ~lock_s;
          state_d  = RSTPLL;
          idx_d    = '0;
          cnt_d    = P_LD;
        end
      end
      FAULT: begin
        cnt_d = cnt;
        idx_d = '0;
      end
      default: begin
        state_d = RSTPLL;
        cnt_d   = P_LD;
        idx_d   = '0;
      end
    endcase
    if (state_d == RUN) retry_d = '0;
  end

  // Outputs, computed from the next state and registered below
  always_comb begin
    pll_rst_d = {NUM_PLL{(state_d == RSTPLL) || (state_d == FAULT)}};
    dom_d     = '1;
    for (int i = 0; i < NUM_PLL; i++) dom_d[i] = !(IW'(i) < idx_d);
    all_locked_d = (state_d == RUN);
    fault_d      = (state_d == FAULT);
    sticky_d     = (clear_status ? '0 : lock_lost_sticky) | lost_set;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      pll_rst          <= '1;
      domain_rst       <= '1;
      all_locked       <= 1'b0;
      fault            <= 1'b0;
      retry_count      <= '0;
      lock_lost_sticky <= '0;
    end else begin
      pll_rst          <= pll_rst_d;
      domain_rst       <= dom_d;
      all_locked       <= all_locked_d;
      fault            <= fault_d;
      retry_count      <= retry_d;
      lock_lost_sticky <= sticky_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

  localparam int N = 2, P = 4, S = 8, T = 32, M = 2, G = 3;
  localparam int PH_RST = 0, PH_WAIT = 1, PH_REL = 2, PH_RUN = 3, PH_FAULT = 4;

  logic         clkin = 1'b0;
  logic         rst = 1'b1;
  logic         clear_status = 1'b0;
  logic [N-1:0] pll_lock_in = '0;
  logic [N-1:0] pll_rst, domain_rst, lock_lost_sticky;
  logic         all_locked, fault;
  logic [1:0]   retry_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clkin = ~clkin;

  pll_lock_supervisor #(
    .NUM_PLL(N), .PLL_RST_CYCLES(P), .LOCK_STABLE_CYCLES(S),
    .LOCK_TIMEOUT_CYCLES(T), .MAX_RETRIES(M), .RST_STAGGER_CYCLES(G)
  ) dut (
    .clkin(clkin), .rst(rst), .pll_lock_in(pll_lock_in), .clear_status(clear_status),
    .pll_rst(pll_rst), .domain_rst(domain_rst), .all_locked(all_locked), .fault(fault),
    .retry_count(retry_count), .lock_lost_sticky(lock_lost_sticky)
  );

  // Reference model: phase plus timestamps (edge numbers since reset).
  typedef struct {
    int ph; int e; int t_ent; int ref_t; int retries;
    logic [N-1:0] sticky; logic [N-1:0] d1; logic [N-1:0] d2;
  } m_t;

  function automatic m_t m_init();
    m_t m;
    m.ph = PH_RST; m.e = 0; m.t_ent = 0; m.ref_t = 0; m.retries = 0;
    m.sticky = '0; m.d1 = '0; m.d2 = '0;
    return m;
  endfunction

  function automatic m_t m_step(input m_t m, input logic [N-1:0] lin, input logic clr);
    m_t n;
    logic [N-1:0] seen, lost;
    n = m; lost = '0;
    seen = m.d2;                 // lock as it was two edges ago
    n.e = m.e + 1; n.d2 = m.d1; n.d1 = lin;
    case (m.ph)
      PH_RST: if (n.e - m.t_ent >= P) begin
        n.ph = PH_WAIT; n.t_ent = n.e; n.ref_t = n.e + 2;
      end
      PH_WAIT: begin
        if (!(&seen)) n.ref_t = n.e;
        if ((&seen) && (n.e - m.ref_t >= S)) begin
          n.ph = PH_REL; n.t_ent = n.e;
        end else if (n.e - m.t_ent >= T) begin
          n.retries = m.retries + 1;
          n.ph = (n.retries >= M) ? PH_FAULT : PH_RST;
          n.t_ent = n.e;
        end
      end
      PH_REL: if (!(&seen)) begin
        lost = ~seen; n.ph = PH_RST; n.t_ent = n.e;
      end else if (n.e - m.t_ent >= (N-1)*G + 1) begin
        n.ph = PH_RUN; n.retries = 0;
      end
      PH_RUN: if (!(&seen)) begin
        lost = ~seen; n.ph = PH_RST; n.t_ent = n.e;
      end
      default: ;
    endcase
    n.sticky = (clr ? '0 : m.sticky) | lost;
    return n;
  endfunction

  function automatic logic [9:0] m_exp(input m_t m);
    logic [N-1:0] pr, dr;
    pr = (m.ph == PH_RST || m.ph == PH_FAULT) ? '1 : '0;
    for (int i = 0; i < N; i++)
      dr[i] = (m.ph == PH_RUN) ? 1'b0 : (m.ph == PH_REL) ? (m.e - m.t_ent < i*G) : 1'b1;
    return {pr, dr, m.ph == PH_RUN, m.ph == PH_FAULT, 2'(m.retries), m.sticky};
  endfunction

  m_t         m;
  logic [9:0] expv, outv;

  always @(posedge clkin or posedge rst)
    if (rst) m <= m_init();
    else     m <= m_step(m, pll_lock_in, clear_status);

  always_comb expv = m_exp(m);
  assign outv = {pll_rst, domain_rst, all_locked, fault, retry_count, lock_lost_sticky};

  task automatic do_reset(input logic [N-1:0] lk);
    rst = 1'b1; pll_lock_in = lk; clear_status = 1'b0;
    repeat (2) @(negedge clkin);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_lock_in = '1; clear_status = 1'b1;
    @(negedge clkin);
    n_total++; if (outv !== 10'b11_11_0_0_00_00) $display("FAIL reset_values got %b want %b", outv, 10'b1111000000); else n_pass++;
    pll_lock_in = 2'b01;
    repeat (3) @(negedge clkin);
    n_total++; if (outv !== 10'b11_11_0_0_00_00) $display("FAIL reset_held got %b want %b", outv, 10'b1111000000); else n_pass++;
    n_total++; if (outv !== expv) $display("FAIL reset_model got %b want %b", outv, expv); else n_pass++;
  endtask

  task automatic test_clean_bringup();
    int t_rel, t_00, t_run;
    t_rel = -1; t_00 = -1; t_run = -1;
    do_reset('0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clkin);
      n_total++; if (outv !== expv) $display("FAIL bringup_model cyc %0d got %b want %b", c, outv, expv); else n_pass++;
      if (c == 3) begin n_total++; if (pll_rst !== 2'b11) $display("FAIL bringup_pllrst_c3 got %b want 11", pll_rst); else n_pass++; end
      if (c == 4) begin n_total++; if (pll_rst !== 2'b00) $display("FAIL bringup_pllrst_c4 got %b want 00", pll_rst); else n_pass++; end
      if (domain_rst === 2'b10 && t_rel < 0) t_rel = c;
      if (domain_rst === 2'b00 && t_00 < 0) t_00 = c;
      if (all_locked === 1'b1 && t_run < 0) t_run = c;
      if (c == 5) pll_lock_in = '1;
    end
    n_total++; if (t_rel < 0 || t_00 - t_rel != G) $display("FAIL bringup_stagger got %0d want %0d", t_00 - t_rel, G); else n_pass++;
    n_total++; if (t_run - t_00 != 1) $display("FAIL bringup_run_delay got %0d want 1", t_run - t_00); else n_pass++;
    n_total++; if (all_locked !== 1'b1 || retry_count !== 2'd0) $display("FAIL bringup_final got locked=%b retry=%0d want 1/0", all_locked, retry_count); else n_pass++;
  endtask

  task automatic test_glitch();
    int k, t_g, t_rel;
    for (int it = 0; it < 3; it++) begin
      k = $urandom_range(1, 6); t_g = -1; t_rel = -1;
      do_reset('1);
      for (int c = 1; c <= 40; c++) begin
        @(negedge clkin);
        n_total++; if (outv !== expv) $display("FAIL glitch_model cyc %0d got %b want %b", c, outv, expv); else n_pass++;
        if (domain_rst !== 2'b11 && t_rel < 0) t_rel = c;
        if (c == 4 + k) begin pll_lock_in[1] = 1'b0; t_g = c; end
        if (c == 5 + k) pll_lock_in[1] = 1'b1;
      end
      n_total++; if (t_rel < 0 || t_rel - t_g < S) $display("FAIL glitch_delay got %0d want >=%0d", t_rel - t_g, S); else n_pass++;
    end
  endtask

  task automatic test_timeout_fault();
    int t_rise, t_fall, t_fault;
    logic [N-1:0] prev;
    t_rise = -1; t_fall = -1; t_fault = -1; prev = 2'b11;
    do_reset(2'b10);
    for (int c = 1; c <= 110; c++) begin
      @(negedge clkin);
      n_total++; if (outv !== expv) $display("FAIL timeout_model cyc %0d got %b want %b", c, outv, expv); else n_pass++;
      if (prev === 2'b00 && pll_rst === 2'b11 && t_rise < 0) begin
        t_rise = c;
        n_total++; if (retry_count !== 2'd1 || fault !== 1'b0) $display("FAIL timeout_retry1 got retry=%0d fault=%b want 1/0", retry_count, fault); else n_pass++;
      end
      if (t_rise >= 0 && t_fall < 0 && pll_rst === 2'b00) t_fall = c;
      if (fault === 1'b1 && t_fault < 0) begin
        t_fault = c;
        n_total++; if (retry_count !== 2'd2 || pll_rst !== 2'b11 || domain_rst !== 2'b11) $display("FAIL timeout_fault_state got retry=%0d pll=%b dom=%b want 2/11/11", retry_count, pll_rst, domain_rst); else n_pass++;
      end
      prev = pll_rst;
      pll_lock_in[1] = 1'($urandom_range(0, 1));
    end
    n_total++; if (t_rise < 0 || t_fall - t_rise != P) $display("FAIL timeout_repulse got %0d want %0d", t_fall - t_rise, P); else n_pass++;
    n_total++; if (fault !== 1'b1 || pll_rst !== 2'b11 || t_fault < 0) $display("FAIL timeout_stays got fault=%b pll=%b want 1/11", fault, pll_rst); else n_pass++;
  endtask

  task automatic test_lock_loss_run();
    int got;
    do_reset('1);
    got = 0;
    for (int c = 1; c <= 60 && got == 0; c++) begin
      @(negedge clkin);
      n_total++; if (outv !== expv) $display("FAIL loss_up_model cyc %0d got %b want %b", c, outv, expv); else n_pass++;
      if (all_locked === 1'b1) got = 1;
    end
    n_total++; if (got == 0) $display("FAIL loss_reach_run got all_locked=%b want 1", all_locked); else n_pass++;
    pll_lock_in = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clkin);
      n_total++; if (outv !== expv) $display("FAIL loss_model edge %0d got %b want %b", k, outv, expv); else n_pass++;
      if (k == 2) begin n_total++; if (domain_rst !== 2'b00) $display("FAIL loss_edge2_dom got %b want 00", domain_rst); else n_pass++; end
      if (k == 3) begin n_total++; if (domain_rst !== 2'b11 || lock_lost_sticky !== 2'b10) $display("FAIL loss_edge3 got dom=%b sticky=%b want 11/10", domain_rst, lock_lost_sticky); else n_pass++; end
    end
    pll_lock_in = '1;
    got = 0;
    for (int c = 1; c <= 60 && got == 0; c++) begin
      @(negedge clkin);
      n_total++; if (outv !== expv) $display("FAIL loss_reseq_model cyc %0d got %b want %b", c, outv, expv); else n_pass++;
      if (all_locked === 1'b1) got = 1;
    end
    n_total++; if (got == 0 || lock_lost_sticky !== 2'b10) $display("FAIL loss_reseq got locked=%b sticky=%b want 1/10", all_locked, lock_lost_sticky); else n_pass++;
    clear_status = 1'b1;
    @(negedge clkin);
    clear_status = 1'b0;
    n_total++; if (lock_lost_sticky !== 2'b00) $display("FAIL loss_clear got %b want 00", lock_lost_sticky); else n_pass++;
    pll_lock_in = 2'b10;
    repeat (2) @(negedge clkin);
    clear_status = 1'b1;
    @(negedge clkin);
    clear_status = 1'b0;
    n_total++; if (lock_lost_sticky !== 2'b01) $display("FAIL loss_set_wins got %b want 01", lock_lost_sticky); else n_pass++;
    n_total++; if (outv !== expv) $display("FAIL loss_set_wins_model got %b want %b", outv, expv); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int got;
    do_reset('1);
    got = 0;
    for (int c = 1; c <= 40 && got == 0; c++) begin
      @(negedge clkin);
      n_total++; if (outv !== expv) $display("FAIL midrst_model cyc %0d got %b want %b", c, outv, expv); else n_pass++;
      if (domain_rst === 2'b10) got = 1;
    end
    n_total++; if (got == 0) $display("FAIL midrst_reach_release got dom=%b want 10", domain_rst); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (outv !== 10'b11_11_0_0_00_00) $display("FAIL midrst_async got %b want %b", outv, 10'b1111000000); else n_pass++;
    @(negedge clkin);
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset('1);
    for (int c = 0; c < 800; c++) begin
      @(negedge clkin);
      n_total++; if (outv !== expv) $display("FAIL random_model cyc %0d got %b want %b", c, outv, expv); else n_pass++;
      rst = (fault === 1'b1);
      for (int i = 0; i < N; i++)
        if (pll_lock_in[i]) pll_lock_in[i] = ($urandom_range(0, 149) != 0);
        else                pll_lock_in[i] = ($urandom_range(0, 3) == 0);
      clear_status = ($urandom_range(0, 15) == 0);
    end
    rst = 1'b0; clear_status = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_bringup();
    test_glitch();
    test_timeout_fault();
    test_lock_loss_run();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
